exp_request_arbiter: RTL and testbench

- Shares one exponent FSMD core (a^n, 6-bit operands/result) between two requesters using round-robin.
- Latches the granted requester's operands and issues a single go pulse to the core.
- Waits for the core's done edge, then returns the result with an ack pulse.
- On each successful job, fires a start pulse to the LCD display controller, with a, n and result held stable.

---
 rtl/exp_request_arbiter.sv | 149 ++++++++++++++
 tb/tb_exp_request_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_request_arbiter.sv
// Round-robin arbiter sharing one exponent core between two requesters; results also go to the LCD.
// Request to ack takes 3 cycles plus the core's WAIT cycles; requesters hold req until their ack.
module exp_request_arbiter #(
    parameter int W       = 6,
    parameter int TIMEOUT = 1000,
    parameter int TW      = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] n0,
    output logic         ack0,
    output logic [W-1:0] res0,
    output logic         err0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] n1,
    output logic         ack1,
    output logic [W-1:0] res1,
    output logic         err1,
    output logic         core_go,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_n,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    output logic         lcd_start,
    output logic [W-1:0] lcd_a,
    output logic [W-1:0] lcd_n,
    output logic [W-1:0] lcd_res,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner;
    logic          last_grant;
    logic          done_q;
    logic [TW-1:0] cnt;

    logic          grant_vld;
    logic          grant_id;
    logic          done_edge;
    logic          timeout_hit;
    logic          finish;
    logic [W-1:0]  fin_res;

    always_comb begin
        state_nxt   = state;
        grant_vld   = 1'b0;
        grant_id    = 1'b0;
        // Only a rising edge counts: a done level left over from a previous job must not complete this one.
        done_edge   = core_done & ~done_q;
        timeout_hit = (cnt == TW'(TIMEOUT - 1));
        finish      = 1'b0;
        fin_res     = done_edge ? core_result : '0;

        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant_vld = 1'b1;
                    grant_id  = ~last_grant;
                end else if (req0) begin
                    grant_vld = 1'b1;
                    grant_id  = 1'b0;
                end else if (req1) begin
                    grant_vld = 1'b1;
                    grant_id  = 1'b1;
                end
                if (grant_vld) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (done_edge || timeout_hit) begin
                    finish    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            done_q     <= 1'b0;
            cnt        <= '0;
            ack0       <= 1'b0;
            res0       <= '0;
            err0       <= 1'b0;
            ack1       <= 1'b0;
            res1       <= '0;
            err1       <= 1'b0;
            core_go    <= 1'b0;
            core_a     <= '0;
            core_n     <= '0;
            lcd_start  <= 1'b0;
            lcd_a      <= '0;
            lcd_n      <= '0;
            lcd_res    <= '0;
            busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_q    <= core_done;
            core_go   <= (state_nxt == ISSUE);
            busy      <= (state_nxt != IDLE);
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            lcd_start <= 1'b0;

            if (state == IDLE && grant_vld) begin
                owner      <= grant_id;
                last_grant <= grant_id;
                core_a     <= grant_id ? a1 : a0;
                core_n     <= grant_id ? n1 : n0;
            end

            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + TW'(1);
            end

            // Outputs for RESP are loaded on the way in so they are valid during the ack cycle.
            if (finish) begin
                if (owner) begin
                    ack1 <= 1'b1;
                    res1 <= fin_res;
                    err1 <= ~done_edge;
                end else begin
                    ack0 <= 1'b1;
                    res0 <= fin_res;
                    err0 <= ~done_edge;
                end
                if (done_edge) begin
                    lcd_start <= 1'b1;
                    lcd_a     <= core_a;
                    lcd_n     <= core_n;
                    lcd_res   <= core_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_exp_request_arbiter.sv
// Bench for exp_request_arbiter: behavioural core model, ack scoreboard and per-scenario tasks.
module tb_exp_request_arbiter;

    localparam int W  = 6;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, n0 = '0, a1 = '0, n1 = '0;
    logic         ack0, ack1, err0, err1;
    logic [W-1:0] res0, res1;
    logic         core_go;
    logic [W-1:0] core_a, core_n;
    logic         core_done = 1'b0;
    logic [W-1:0] core_result = '0;
    logic         lcd_start;
    logic [W-1:0] lcd_a, lcd_n, lcd_res;
    logic         busy;

    exp_request_arbiter #(.W(W), .TIMEOUT(TO), .TW(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .n0(n0), .ack0(ack0), .res0(res0), .err0(err0),
        .req1(req1), .a1(a1), .n1(n1), .ack1(ack1), .res1(res1), .err1(err1),
        .core_go(core_go), .core_a(core_a), .core_n(core_n),
        .core_done(core_done), .core_result(core_result),
        .lcd_start(lcd_start), .lcd_a(lcd_a), .lcd_n(lcd_n), .lcd_res(lcd_res),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire [8*W+7:0] all_out = {ack0, res0, err0, ack1, res1, err1, core_go, core_a, core_n,
                              lcd_start, lcd_a, lcd_n, lcd_res, busy};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         owner;
        logic [W-1:0] a;
        logic [W-1:0] n;
        logic [W-1:0] res;
        logic         err;
    } exp_t;
    exp_t sbq[$];

    logic [W-1:0] m_res[2];
    logic         m_err[2];
    logic [W-1:0] m_lcd_a, m_lcd_n, m_lcd_res;
    int           go_count = 0;
    bit           core_manual = 1'b0;

    // Behavioural core: result appears 4 cycles after go and stays as a level until the next go.
    initial begin
        int           dly;
        logic [W-1:0] ma, mn, p;
        dly = 0; ma = '0; mn = '0; p = '0;
        forever begin
            @(posedge clk); #1;
            if (!core_manual) begin
                if (core_go) begin
                    core_done = 1'b0;
                    dly = 4;
                    ma = core_a;
                    mn = core_n;
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        p = 1;
                        for (int k = 0; k < int'(mn); k++) p = W'(p * ma);
                        core_result = p;
                        core_done = 1'b1;
                    end
                end
            end
        end
    end

    // Scoreboard: every ack pops one expectation and checks both requesters' outputs and the LCD.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (core_go) go_count++;
            if (ack0 || ack1) begin
                checks++;
                if (ack0 && ack1) begin
                    errors++;
                    $display("FAIL dual_ack: ack0=%0d ack1=%0d want only one", ack0, ack1);
                end else if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: ack0=%0d ack1=%0d with no job pending", ack0, ack1);
                end else begin
                    e = sbq.pop_front();
                    checks++;
                    if (ack1 !== e.owner) begin
                        errors++;
                        $display("FAIL ack_owner: got %0d want %0d", ack1, e.owner);
                    end
                    m_res[e.owner] = e.res;
                    m_err[e.owner] = e.err;
                    if (!e.err) begin
                        m_lcd_a = e.a; m_lcd_n = e.n; m_lcd_res = e.res;
                    end
                    checks++;
                    if (res0 !== m_res[0] || err0 !== m_err[0]) begin
                        errors++;
                        $display("FAIL res0_err0: got %0d/%0d want %0d/%0d", res0, err0, m_res[0], m_err[0]);
                    end
                    checks++;
                    if (res1 !== m_res[1] || err1 !== m_err[1]) begin
                        errors++;
                        $display("FAIL res1_err1: got %0d/%0d want %0d/%0d", res1, err1, m_res[1], m_err[1]);
                    end
                    checks++;
                    if (lcd_start !== !e.err) begin
                        errors++;
                        $display("FAIL lcd_start: got %0d want %0d", lcd_start, !e.err);
                    end
                    checks++;
                    if (lcd_a !== m_lcd_a || lcd_n !== m_lcd_n || lcd_res !== m_lcd_res) begin
                        errors++;
                        $display("FAIL lcd_values: got %0d,%0d,%0d want %0d,%0d,%0d",
                                 lcd_a, lcd_n, lcd_res, m_lcd_a, m_lcd_n, m_lcd_res);
                    end
                end
            end
        end
    end

    task automatic clear_model();
        m_res[0] = '0; m_res[1] = '0;
        m_err[0] = 1'b0; m_err[1] = 1'b0;
        m_lcd_a = '0; m_lcd_n = '0; m_lcd_res = '0;
    endtask

    int unsigned go_cyc;
    bit          found;

    task automatic wait_go(input string name);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (core_go) begin found = 1'b1; break; end
        end
        go_cyc = cyc;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_go_timeout: core_go=0 want 1 within 40 cycles", name);
        end
    endtask

    task automatic wait_ack(input bit who, input string name);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if ((who ? ack1 : ack0) === 1'b1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_ack_timeout: ack%0d=0 want 1 within 60 cycles", name, who);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0; a0 = 3; n0 = 3;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        clear_model();
        go_count = 0;
        sbq.push_back('{1'b0, 6'd3, 6'd3, 6'd27, 1'b0});
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (core_go !== 1'b1 || core_a !== 6'd3 || core_n !== 6'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: go=%0d a=%0d n=%0d busy=%0d want 1,3,3,1", core_go, core_a, core_n, busy);
        end
        go_cyc = cyc;
    endtask

    task automatic test_single();
        wait_ack(1'b0, "single");
        checks++;
        if (cyc - go_cyc != 5) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles go->ack want 5", cyc - go_cyc);
        end
        checks++;
        if (ack1 !== 1'b0) begin
            errors++;
            $display("FAIL single_ack1: got %0d want 0", ack1);
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ack0 !== 1'b0 || lcd_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_end: ack0=%0d lcd_start=%0d busy=%0d want 0,0,0", ack0, lcd_start, busy);
        end
        checks++;
        if (go_count != 1) begin
            errors++;
            $display("FAIL single_go_count: got %0d want 1", go_count);
        end
    endtask

    task automatic test_tie();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        a0 = 2; n0 = 3; a1 = 2; n1 = 4;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        sbq.push_back('{1'b0, 6'd2, 6'd3, 6'd8, 1'b0});
        sbq.push_back('{1'b1, 6'd2, 6'd4, 6'd16, 1'b0});
        rst = 1'b0;
        wait_ack(1'b0, "tie_first");
        req0 = 1'b0;
        wait_ack(1'b1, "tie_second");
        req1 = 1'b0;
        @(posedge clk); #1;
        sbq.push_back('{1'b0, 6'd1, 6'd5, 6'd1, 1'b0});
        sbq.push_back('{1'b1, 6'd3, 6'd2, 6'd9, 1'b0});
        req0 = 1'b1; req1 = 1'b1;
        a0 = 1; n0 = 5; a1 = 3; n1 = 2;
        wait_go("tie_round2");
        checks++;
        if (core_a !== 6'd1 || core_n !== 6'd5) begin
            errors++;
            $display("FAIL tie_alternation: core_a=%0d core_n=%0d want 1,5", core_a, core_n);
        end
        // Operands changing mid-job must not reach the core or the LCD.
        a0 = 7; n0 = 7;
        wait_ack(1'b0, "tie_third");
        req0 = 1'b0;
        wait_ack(1'b1, "tie_fourth");
        req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        core_manual = 1'b1; core_done = 1'b0;
        sbq.push_back('{1'b1, 6'd5, 6'd2, 6'd0, 1'b1});
        req1 = 1'b1; a1 = 5; n1 = 2;
        wait_go("timeout");
        wait_ack(1'b1, "timeout");
        checks++;
        if (cyc - go_cyc != TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles go->ack want %0d", cyc - go_cyc, TO + 1);
        end
        req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stale_done();
        core_done = 1'b1; core_result = 6'd0;
        sbq.push_back('{1'b0, 6'd3, 6'd2, 6'd9, 1'b0});
        req0 = 1'b1; a0 = 3; n0 = 2;
        wait_go("stale");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack0 !== 1'b0) begin
                errors++;
                $display("FAIL stale_no_complete: ack0=%0d want 0 at wait cycle %0d", ack0, i);
            end
        end
        core_done = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ack0 !== 1'b0) begin
            errors++;
            $display("FAIL stale_low_phase: ack0=%0d want 0", ack0);
        end
        @(posedge clk); #1;
        core_done = 1'b1; core_result = 6'd9;
        @(posedge clk); #1;
        checks++;
        if (ack0 !== 1'b1 || res0 !== 6'd9 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL stale_rising_edge: ack0=%0d res0=%0d err0=%0d want 1,9,0", ack0, res0, err0);
        end
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        core_done = 1'b0;
        req0 = 1'b1; a0 = 2; n0 = 5;
        wait_go("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 0", all_out);
        end
        clear_model();
        sbq.push_back('{1'b0, 6'd2, 6'd5, 6'd32, 1'b0});
        core_manual = 1'b0;
        rst = 1'b0;
        wait_go("midrst_regrant");
        checks++;
        if (core_a !== 6'd2 || core_n !== 6'd5) begin
            errors++;
            $display("FAIL midrst_regrant_ops: core_a=%0d core_n=%0d want 2,5", core_a, core_n);
        end
        wait_ack(1'b0, "midrst");
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        clear_model();
        test_reset();
        test_single();
        test_tie();
        test_timeout();
        test_stale_done();
        test_reset_mid_wait();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d jobs left want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
